approx_mult_scheduler: RTL and testbench

Round-robin scheduler that shares one instance of the 4x4 approximate multiplier among `NUM_REQ` requesters. It sits between client datapaths and the multiplier. It:

- accepts operand pairs through per-requester valid/ready handshakes,
- issues one operation per cycle to the multiplier,
- tracks in-flight operations with a tag pipeline,
- routes each product back to the requester that issued it.

Throughput is one multiply per clock. Results return in issue order.

---
 rtl/approx_mult_scheduler.sv | 126 ++++++++++++
 tb/tb_approx_mult_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_scheduler.sv
// Round-robin front end that time-shares one 4x4 approximate multiplier among
// NUM_REQ requesters, tagging each issue so its product is routed back in order.
module approx_mult_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*4-1:0] req_a_i,
  input  logic [NUM_REQ*4-1:0] req_b_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [NUM_REQ*8-1:0] rsp_product_o,
  output logic [3:0]           mult_a_o,
  output logic [3:0]           mult_b_o,
  input  logic [7:0]           mult_product_i,
  output logic                 busy_o
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int NST = MULT_LATENCY + 1;

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      cand;
  logic               grant_any;
  logic               accept;

  logic [3:0]         a_arr [NUM_REQ];
  logic [3:0]         b_arr [NUM_REQ];
  logic [3:0]         mult_a_reg;
  logic [3:0]         mult_b_reg;

  logic [NST-1:0]     tag_valid_reg;
  logic [PW-1:0]      tag_idx_reg [NST];

  logic [NUM_REQ-1:0] ret_hit;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [7:0]         rsp_product_reg [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a_i[4*gi +: 4];
      assign b_arr[gi] = req_b_i[4*gi +: 4];
      assign rsp_product_o[8*gi +: 8] = rsp_product_reg[gi];
      assign ret_hit[gi] = tag_valid_reg[NST-1] && (tag_idx_reg[NST-1] == PW'(gi));
    end
  endgenerate

  // Walk the ring backwards so the candidate closest to ptr is the last writer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = PW'((int'(ptr_reg) + off) % NUM_REQ);
      if (req_valid_i[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  assign accept      = grant_any & ~rst_i;
  assign req_ready_o = rst_i ? '0 : grant;
  assign ptr_next    = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Operand registers only move on an accept so the multiplier sees no toggling when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg       <= '0;
      mult_a_reg    <= '0;
      mult_b_reg    <= '0;
      tag_valid_reg <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[NST-2:0], accept};
      if (accept) begin
        ptr_reg    <= ptr_next;
        mult_a_reg <= a_arr[grant_idx];
        mult_b_reg <= b_arr[grant_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NST; s++) begin
        tag_idx_reg[s] <= '0;
      end
    end else begin
      tag_idx_reg[0] <= grant_idx;
      for (int s = 1; s < NST; s++) begin
        tag_idx_reg[s] <= tag_idx_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_reg <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        rsp_product_reg[r] <= '0;
      end
    end else begin
      rsp_valid_reg <= ret_hit;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (ret_hit[r]) begin
          rsp_product_reg[r] <= mult_product_i;
        end
      end
    end
  end

  assign mult_a_o    = mult_a_reg;
  assign mult_b_o    = mult_b_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign busy_o      = |tag_valid_reg;

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Randomized and directed bench for approx_mult_scheduler, checked against a
// queue-based model of arbitration order and fixed return latency.
module tb_approx_mult_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  mult_product;
  wire  [3:0]  req_ready;
  wire  [3:0]  rsp_valid;
  wire  [31:0] rsp_product;
  wire  [3:0]  mult_a;
  wire  [3:0]  mult_b;
  wire         busy;

  always #5 clk = ~clk;

  // Exact multiplier with one edge of latency.
  always @(posedge clk) mult_product <= mult_a * mult_b;

  approx_mult_scheduler #(.NUM_REQ(N), .MULT_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_product_o(rsp_product),
    .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_product_i(mult_product), .busy_o(busy)
  );

  typedef struct {int cnt; int idx; logic [7:0] p;} pend_t;
  pend_t       pend[$];
  int          m_ptr = 0;
  logic [3:0]  m_a = '0, m_b = '0;
  logic [7:0]  m_prod [N];
  logic [3:0]  exp_ready, obs_ready, exp_rsp;
  logic        exp_busy;
  int          last_grant = -1;
  int          checks = 0, failures = 0;

  function automatic int pick(logic [3:0] v, int p);
    for (int off = 0; off < N; off++) begin
      int k;
      k = (p + off) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Advance one clock: predict the grant, then apply the edge to the model.
  task automatic tick();
    int g;
    logic [3:0] ga, gb;
    pend_t e, keep[$];
    #1;
    g = rst ? -1 : pick(req_valid, m_ptr);
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
    obs_ready = req_ready;
    last_grant = g;
    ga = '0; gb = '0;
    if (g >= 0) begin
      ga = req_a[4*g +: 4];
      gb = req_b[4*g +: 4];
    end
    @(posedge clk);
    #1;
    exp_rsp = '0;
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_a = '0; m_b = '0;
      foreach (m_prod[k]) m_prod[k] = '0;
    end else begin
      foreach (pend[i]) begin
        e = pend[i];
        e.cnt--;
        if (e.cnt == 0) begin
          exp_rsp[e.idx] = 1'b1;
          m_prod[e.idx] = e.p;
        end else keep.push_back(e);
      end
      pend = keep;
      if (g >= 0) begin
        e.cnt = 2; e.idx = g; e.p = 8'(ga) * 8'(gb);
        pend.push_back(e);
        m_ptr = (g + 1) % N;
        m_a = ga; m_b = gb;
      end
    end
    exp_busy = (pend.size() > 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_a = 16'h1234; req_b = 16'h5678;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", obs_ready); end
      checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
      checks++; if (rsp_product !== 32'b0) begin failures++; $display("FAIL reset_product got=%h want=0", rsp_product); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if ({mult_a, mult_b} !== 8'h00) begin failures++; $display("FAIL reset_mult got=%h%h want=00", mult_a, mult_b); end
    end
    rst = 1'b0; req_valid = '0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_a[11:8] = 4'd3; req_b[11:8] = 4'd5;
    tick();
    checks++; if (obs_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b want=0100", obs_ready); end
    checks++; if ({mult_a, mult_b} !== {4'd3, 4'd5}) begin failures++; $display("FAIL single_issue got=%0d,%0d want=3,5", mult_a, mult_b); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", busy); end
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL single_early got=%b want=0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL single_pulse got=%b want=0100", rsp_valid); end
    checks++; if (rsp_product[23:16] !== 8'd15) begin failures++; $display("FAIL single_product got=%0d want=15", rsp_product[23:16]); end
    tick();
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL single_one_cycle got=%b want=0000", rsp_valid); end
    checks++; if (rsp_product[23:16] !== 8'd15) begin failures++; $display("FAIL single_hold got=%0d want=15", rsp_product[23:16]); end
    $display("test_single done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_all_requesters();
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = 4'(i + 1);
      req_b[4*i +: 4] = 4'd2;
    end
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req_valid = '0;
      tick();
      checks++;
      if (obs_ready !== ((c < 5) ? 4'(1 << (c % 4)) : 4'b0)) begin
        failures++; $display("FAIL all_grant cyc=%0d got=%b want=%b", c, obs_ready, (c < 5) ? 4'(1 << (c % 4)) : 4'b0);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 4'(1 << ((c - 2) % 4))) begin
          failures++; $display("FAIL all_pulse cyc=%0d got=%b want=%b", c, rsp_valid, 4'(1 << ((c - 2) % 4)));
        end
        checks++;
        if (rsp_product[8*((c-2)%4) +: 8] !== 8'(2 * ((c - 2) % 4 + 1))) begin
          failures++; $display("FAIL all_product cyc=%0d got=%0d want=%0d", c, rsp_product[8*((c-2)%4) +: 8], 2 * ((c - 2) % 4 + 1));
        end
      end
    end
    $display("test_all_requesters done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fairness();
    int wait3;
    do_reset();
    req_valid = 4'b1001;
    wait3 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        failures++; $display("FAIL fair_grant cyc=%0d got=%b want=%b", c, obs_ready, (c % 2 == 0) ? 4'b0001 : 4'b1000);
      end
      wait3 = obs_ready[3] ? 0 : wait3 + 1;
      checks++;
      if (wait3 > N - 1) begin failures++; $display("FAIL fair_wait cyc=%0d got=%0d want<=%0d", c, wait3, N - 1); end
    end
    req_valid = '0;
    tick(); tick();
    $display("test_fairness done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0010; req_a[7:4] = 4'd7; req_b[7:4] = 4'd7;
    tick();
    checks++; if (obs_ready !== 4'b0010) begin failures++; $display("FAIL mid_grant got=%b want=0010", obs_ready); end
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after_reset got=%b want=0", busy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL mid_no_pulse cyc=%0d got=%b want=0000", c, rsp_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy cyc=%0d got=%b want=0", c, busy); end
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_idle_hold();
    do_reset();
    req_valid = 4'b0001; req_a[3:0] = 4'd9; req_b[3:0] = 4'd4;
    tick();
    req_valid = '0; req_a = 16'hABCD; req_b = 16'h1357;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++; if ({mult_a, mult_b} !== {4'd9, 4'd4}) begin failures++; $display("FAIL idle_mult cyc=%0d got=%0d,%0d want=9,4", c, mult_a, mult_b); end
      checks++; if (busy !== (c == 1)) begin failures++; $display("FAIL idle_busy cyc=%0d got=%b want=%b", c, busy, c == 1); end
      if (c >= 2) begin
        checks++; if (rsp_product[7:0] !== 8'd36) begin failures++; $display("FAIL idle_product cyc=%0d got=%0d want=36", c, rsp_product[7:0]); end
        checks++; if (rsp_valid !== ((c == 2) ? 4'b0001 : 4'b0)) begin failures++; $display("FAIL idle_pulse cyc=%0d got=%b", c, rsp_valid); end
      end
    end
    $display("test_idle_hold done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    do_reset();
    last_grant = -1;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      for (int k = 0; k < N; k++) begin
        if (last_grant == k || !req_valid[k]) begin
          req_valid[k] = ($urandom_range(0, 99) < 60);
          req_a[4*k +: 4] = 4'($urandom);
          req_b[4*k +: 4] = 4'($urandom);
        end else if ($urandom_range(0, 99) < 5) begin
          req_valid[k] = 1'b0;
        end
      end
      tick();
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++; if (rsp_valid !== exp_rsp) begin failures++; $display("FAIL rand_pulse cyc=%0d got=%b want=%b", c, rsp_valid, exp_rsp); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, busy, exp_busy); end
      checks++; if ({mult_a, mult_b} !== {m_a, m_b}) begin failures++; $display("FAIL rand_mult cyc=%0d got=%h%h want=%h%h", c, mult_a, mult_b, m_a, m_b); end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rsp_product[8*k +: 8] !== m_prod[k]) begin
          failures++; $display("FAIL rand_product cyc=%0d req=%0d got=%0d want=%0d", c, k, rsp_product[8*k +: 8], m_prod[k]);
        end
      end
    end
    rst = 1'b0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    foreach (m_prod[k]) m_prod[k] = '0;
    test_reset();
    test_single();
    test_all_requesters();
    test_fairness();
    test_reset_mid();
    test_idle_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
